dense_layer_sequencer: RTL and testbench
========================================

Name: dense_layer_sequencer

Overview:
- Control sequencer for one fully-connected MLP layer built around a single shared pipelined FP32 multiply-accumulate unit (fp_mac).
- Walks neurons and inputs, issues weight, input and bias memory reads, and feeds the MAC with first/last framing.
- Applies ReLU to each finished sum and writes it to the layer output RAM.
- Replaces per-neuron weight-vector copying: weights stay in RAM, addressed incrementally.

Parameters:
- N_NEURONS, 128: neurons (outputs) in the layer.
- N_INPUTS, 784: inputs per neuron.
- N_WEIGHTS, 100352: N_NEURONS*N_INPUTS; sets w_addr width.
- END_LAYER, 0: 1 = final layer, ReLU bypassed.
- RES_TIMEOUT, 64: max cycles to wait for mac_res_valid before flagging an error.

Ports:
- CLK in 1: clock, all logic on posedge.
- reset in 1: synchronous, active-high.
- start in 1: pulse that begins a layer pass; typically the previous layer's layer_end.
- busy out 1: high from the cycle after an accepted start until done.
- layer_end out 1: one-cycle pulse after the last output write.
- err out 1: sticky result-timeout or unexpected-result flag; cleared only by reset.
- mem_rd out 1: read strobe for the input, weight and bias RAMs; data valid the next cycle.
- in_addr out $clog2(N_INPUTS): input RAM address.
- w_addr out $clog2(N_WEIGHTS): weight RAM address.
- b_addr out $clog2(N_NEURONS): bias RAM address; also used as out_addr.
- mac_valid out 1: operand beat valid at the MAC (RAM data + framing).
- mac_first out 1: first beat of a neuron; the MAC accumulator loads bias + w*x.
- mac_last out 1: last beat of a neuron.
- mac_ready in 1: MAC accepts the beat when mac_valid && mac_ready.
- mac_res_valid in 1: one-cycle pulse, final sum available.
- mac_res in 32: FP32 IEEE-754 sum.
- out_we out 1: output RAM write enable.
- out_addr out $clog2(N_NEURONS): output index.
- out_data out 32: activated value.

Behaviour:
- Reset values:
  - busy, layer_end, err, mem_rd, mac_valid, mac_first, mac_last and out_we are 0.
  - All addresses and out_data are 0.
  - State is IDLE; counters are cleared.
  - Reset mid-pass aborts immediately with no layer_end pulse.
- States: IDLE, ISSUE, DRAIN, WAIT_RES, WRITE, DONE.
- IDLE:
  - start=1 moves to ISSUE and clears the neuron counter n, input counter k and w_addr.
  - start is ignored in every other state.
- ISSUE, each cycle with no stall:
  - mem_rd=1, in_addr=k, w_addr=n*N_INPUTS+k (incremental, no multiplier), b_addr=n.
  - k increments each cycle.
  - One cycle later mac_valid=1 with mac_first=(k==0) and mac_last=(k==N_INPUTS-1), registered to align with the 1-cycle RAM latency.
  - After issuing k=N_INPUTS-1, go to DRAIN.
- Stall:
  - If mac_valid && !mac_ready, hold mac_valid/first/last and hold addresses with mem_rd=0.
  - RAM outputs are held, so the beat is unchanged.
  - Issue resumes the cycle after mac_ready rises.
- DRAIN: wait until the last beat is accepted, then go to WAIT_RES and clear the timeout counter.
- WAIT_RES:
  - On mac_res_valid, capture mac_res and go to WRITE.
  - If the counter reaches RES_TIMEOUT, set err and go to WRITE with out_data=0.
- WRITE (one cycle):
  - out_we=1, out_addr=n.
  - out_data=0 when END_LAYER==0 and mac_res[31]=1 (negative values and -0.0 included); otherwise mac_res unchanged, NaN included.
  - If n==N_NEURONS-1, go to DONE; else n++, k=0, and return to ISSUE.
- DONE: layer_end=1 for one cycle, busy=0, next state IDLE.
- mac_res_valid outside WAIT_RES is ignored and sets err.
- N_INPUTS=1: mac_first and mac_last are asserted on the same beat.
- Latency per neuron with no stalls is N_INPUTS+1 cycles plus MAC latency plus 2 cycles (capture + write).

Decomposition:
- mlp_pkg holds:
  - FP_W=32;
  - the sequencer state enum;
  - FP_SIGN=31;
  - function relu_fp32(val, bypass).
- No sub-module is needed: address generation and framing stay in one FSM block.
- fp_mac is external; the bench substitutes a behavioural model with configurable latency.

Test Plan:
- N_NEURONS=2, N_INPUTS=3, mac_ready=1, MAC latency 4:
  - w_addr sequence is 0,1,2 then 3,4,5;
  - mac_first on beats 0 and 3, mac_last on beats 2 and 5;
  - layer_end comes 1 cycle after the second out_we.
- Sum for neuron 0 = 0xC0400000 (-3.0), END_LAYER=0 -> out_data 0x00000000 at out_addr 0. Repeat with END_LAYER=1 -> 0xC0400000.
- mac_ready low for 3 cycles on beat 1 -> beat 1 is held stable, no address advance, final w_addr sequence unchanged, correct sums.
- mac_res_valid withheld for RES_TIMEOUT cycles -> err=1, out_data=0, layer still completes with a layer_end pulse.
- reset asserted during ISSUE of neuron 1 -> next cycle all outputs 0, no layer_end. A new start then runs a full correct pass.
- N_INPUTS=1 -> each beat carries both mac_first and mac_last; start pulses while busy produce no extra pass.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the dense-layer sequencer: FP32 field positions,
// sequencer state encoding and the ReLU applied to finished neuron sums.
package mlp_pkg;

  localparam int FP_W    = 32;
  localparam int FP_SIGN = 31;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_DRAIN    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } seq_state_e;

  // Sign-bit ReLU: any value with the sign set (including -0.0) becomes +0.0; NaNs pass through.
  function automatic logic [FP_W-1:0] relu_fp32(input logic [FP_W-1:0] val, input logic bypass);
    logic [FP_W-1:0] res;
    if (!bypass && val[FP_SIGN]) begin
      res = {FP_W{1'b0}};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/dense_layer_sequencer.sv
// Sequencer for one fully-connected layer: streams input/weight/bias reads into a shared
// pipelined FP32 MAC with first/last framing, then ReLUs and stores each neuron's sum.
module dense_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_NEURONS   = 128,
  parameter int N_INPUTS    = 784,
  parameter int N_WEIGHTS   = N_NEURONS * N_INPUTS,
  parameter int END_LAYER   = 0,
  parameter int RES_TIMEOUT = 64,
  localparam int IA_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
  localparam int WA_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1,
  localparam int BA_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            layer_end,
  output logic            err,
  output logic            mem_rd,
  output logic [IA_W-1:0] in_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [BA_W-1:0] b_addr,
  output logic            mac_valid,
  output logic            mac_first,
  output logic            mac_last,
  input  logic            mac_ready,
  input  logic            mac_res_valid,
  input  logic [FP_W-1:0] mac_res,
  output logic            out_we,
  output logic [BA_W-1:0] out_addr,
  output logic [FP_W-1:0] out_data
);

  localparam int TW = $clog2(RES_TIMEOUT + 1);
  localparam logic [IA_W-1:0] K_LAST   = IA_W'(N_INPUTS - 1);
  localparam logic [BA_W-1:0] N_LAST   = BA_W'(N_NEURONS - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(RES_TIMEOUT - 1);

  seq_state_e      state_r, state_s;
  logic [IA_W-1:0] in_addr_r, in_addr_s;
  logic [WA_W-1:0] w_addr_r, w_addr_s;
  logic [BA_W-1:0] b_addr_r, b_addr_s;
  logic            mac_valid_r, mac_valid_s;
  logic            mac_first_r, mac_first_s;
  logic            mac_last_r, mac_last_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic [FP_W-1:0] res_r, res_s;
  logic            out_we_r, out_we_s;
  logic [BA_W-1:0] out_addr_r, out_addr_s;
  logic [FP_W-1:0] out_data_r, out_data_s;
  logic            busy_r, busy_s;
  logic            layer_end_r, layer_end_s;
  logic            err_r, err_s;
  logic            stall_s;
  logic            rd_s;

  // Next-state, address generation and MAC framing.
  always_comb begin
    stall_s     = mac_valid_r && !mac_ready;
    // The read strobe must drop in the very cycle the MAC stalls, so it is decoded, not registered.
    rd_s        = (state_r == S_ISSUE) && !stall_s;
    state_s     = state_r;
    in_addr_s   = in_addr_r;
    w_addr_s    = w_addr_r;
    b_addr_s    = b_addr_r;
    tmo_s       = tmo_r;
    res_s       = res_r;
    out_we_s    = 1'b0;
    out_addr_s  = out_addr_r;
    out_data_s  = out_data_r;
    layer_end_s = 1'b0;
    err_s       = err_r | (mac_res_valid && (state_r != S_WAIT_RES));

    if (stall_s) begin
      mac_valid_s = mac_valid_r;
      mac_first_s = mac_first_r;
      mac_last_s  = mac_last_r;
    end else if (rd_s) begin
      mac_valid_s = 1'b1;
      mac_first_s = (in_addr_r == {IA_W{1'b0}});
      mac_last_s  = (in_addr_r == K_LAST);
    end else begin
      mac_valid_s = 1'b0;
      mac_first_s = 1'b0;
      mac_last_s  = 1'b0;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s   = S_ISSUE;
          in_addr_s = {IA_W{1'b0}};
          w_addr_s  = {WA_W{1'b0}};
          b_addr_s  = {BA_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (rd_s) begin
          // w_addr simply keeps counting across neurons, tracking n*N_INPUTS+k.
          w_addr_s = w_addr_r + WA_W'(1);
          if (in_addr_r == K_LAST) begin
            in_addr_s = {IA_W{1'b0}};
            state_s   = S_DRAIN;
          end else begin
            in_addr_s = in_addr_r + IA_W'(1);
          end
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (!stall_s) begin
          state_s = S_WAIT_RES;
          tmo_s   = {TW{1'b0}};
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_WAIT_RES: begin
        if (mac_res_valid) begin
          res_s   = mac_res;
          state_s = S_WRITE;
        end else if (tmo_r == TMO_LAST) begin
          err_s   = 1'b1;
          res_s   = {FP_W{1'b0}};
          state_s = S_WRITE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      S_WRITE: begin
        out_we_s   = 1'b1;
        out_addr_s = b_addr_r;
        out_data_s = relu_fp32(res_r, END_LAYER != 0);
        if (b_addr_r == N_LAST) begin
          state_s = S_DONE;
        end else begin
          b_addr_s = b_addr_r + BA_W'(1);
          state_s  = S_ISSUE;
        end
      end
      S_DONE: begin
        layer_end_s = 1'b1;
        state_s     = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s = (state_s != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r     <= S_IDLE;
      in_addr_r   <= {IA_W{1'b0}};
      w_addr_r    <= {WA_W{1'b0}};
      b_addr_r    <= {BA_W{1'b0}};
      mac_valid_r <= 1'b0;
      mac_first_r <= 1'b0;
      mac_last_r  <= 1'b0;
      tmo_r       <= {TW{1'b0}};
      res_r       <= {FP_W{1'b0}};
      out_we_r    <= 1'b0;
      out_addr_r  <= {BA_W{1'b0}};
      out_data_r  <= {FP_W{1'b0}};
      busy_r      <= 1'b0;
      layer_end_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_addr_r   <= in_addr_s;
      w_addr_r    <= w_addr_s;
      b_addr_r    <= b_addr_s;
      mac_valid_r <= mac_valid_s;
      mac_first_r <= mac_first_s;
      mac_last_r  <= mac_last_s;
      tmo_r       <= tmo_s;
      res_r       <= res_s;
      out_we_r    <= out_we_s;
      out_addr_r  <= out_addr_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
      layer_end_r <= layer_end_s;
      err_r       <= err_s;
    end
  end

  assign mem_rd    = rd_s;
  assign in_addr   = in_addr_r;
  assign w_addr    = w_addr_r;
  assign b_addr    = b_addr_r;
  assign mac_valid = mac_valid_r;
  assign mac_first = mac_first_r;
  assign mac_last  = mac_last_r;
  assign out_we    = out_we_r;
  assign out_addr  = out_addr_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign layer_end = layer_end_r;
  assign err       = err_r;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench: three sequencers (2x3 hidden, 2x3 final, 2x1 hidden) fed by behavioural RAMs and
// integer-accumulating MAC models; outputs are checked against sums computed from the memories.
module tb_dense_layer_sequencer;

  localparam int NN = 2, NI = 3, NIC = 1, LAT = 4, TMO = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset, start, rdy_a, wh;
  logic [31:0] x_mem [0:3];
  logic [31:0] w_mem [0:7];
  logic [31:0] b_mem [0:1];

  logic busy_a, le_a, err_a, mrd_a, mv_a, mfst_a, mlst_a, owe_a, rv_a;
  logic [1:0] ia_a; logic [2:0] wa_a; logic [0:0] ba_a, oadr_a; logic [31:0] odat_a, res_a;
  logic busy_b, le_b, err_b, mrd_b, mv_b, mfst_b, mlst_b, owe_b;
  logic [1:0] ia_b; logic [2:0] wa_b; logic [0:0] ba_b, oadr_b; logic [31:0] odat_b;
  logic busy_c, le_c, err_c, mrd_c, mv_c, mfst_c, mlst_c, owe_c, rv_c;
  logic [0:0] ia_c, wa_c, ba_c, oadr_c; logic [31:0] odat_c, res_c;

  dense_layer_sequencer #(.N_NEURONS(NN), .N_INPUTS(NI), .N_WEIGHTS(NN*NI), .END_LAYER(0), .RES_TIMEOUT(TMO)) u_a (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy_a), .layer_end(le_a), .err(err_a),
    .mem_rd(mrd_a), .in_addr(ia_a), .w_addr(wa_a), .b_addr(ba_a), .mac_valid(mv_a),
    .mac_first(mfst_a), .mac_last(mlst_a), .mac_ready(rdy_a), .mac_res_valid(rv_a), .mac_res(res_a),
    .out_we(owe_a), .out_addr(oadr_a), .out_data(odat_a));

  dense_layer_sequencer #(.N_NEURONS(NN), .N_INPUTS(NI), .N_WEIGHTS(NN*NI), .END_LAYER(1), .RES_TIMEOUT(TMO)) u_b (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy_b), .layer_end(le_b), .err(err_b),
    .mem_rd(mrd_b), .in_addr(ia_b), .w_addr(wa_b), .b_addr(ba_b), .mac_valid(mv_b),
    .mac_first(mfst_b), .mac_last(mlst_b), .mac_ready(rdy_a), .mac_res_valid(rv_a), .mac_res(res_a),
    .out_we(owe_b), .out_addr(oadr_b), .out_data(odat_b));

  dense_layer_sequencer #(.N_NEURONS(NN), .N_INPUTS(NIC), .N_WEIGHTS(NN*NIC), .END_LAYER(0), .RES_TIMEOUT(TMO)) u_c (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy_c), .layer_end(le_c), .err(err_c),
    .mem_rd(mrd_c), .in_addr(ia_c), .w_addr(wa_c), .b_addr(ba_c), .mac_valid(mv_c),
    .mac_first(mfst_c), .mac_last(mlst_c), .mac_ready(1'b1), .mac_res_valid(rv_c), .mac_res(res_c),
    .out_we(owe_c), .out_addr(oadr_c), .out_data(odat_c));

  // RAMs (1-cycle read, output held) and MAC models with LAT cycles of result latency.
  logic [31:0] xq_a, wq_a, bq_a, acc_a, nacc_a, xq_c, wq_c, bq_c, acc_c, nacc_c;
  logic [LAT-1:0] pv_a, pv_c;
  logic [31:0] pd_a [LAT];
  logic [31:0] pd_c [LAT];
  assign nacc_a = (mfst_a ? bq_a : acc_a) + wq_a * xq_a;
  assign nacc_c = (mfst_c ? bq_c : acc_c) + wq_c * xq_c;
  assign rv_a = pv_a[LAT-1];
  assign res_a = pd_a[LAT-1];
  assign rv_c = pv_c[LAT-1];
  assign res_c = pd_c[LAT-1];

  always @(posedge CLK) begin
    if (reset) begin
      pv_a <= '0; acc_a <= '0; pv_c <= '0; acc_c <= '0;
    end else begin
      if (mrd_a) begin xq_a <= x_mem[ia_a]; wq_a <= w_mem[wa_a]; bq_a <= b_mem[ba_a]; end
      if (mrd_c) begin xq_c <= x_mem[ia_c]; wq_c <= w_mem[wa_c]; bq_c <= b_mem[ba_c]; end
      pv_a <= {pv_a[LAT-2:0], mv_a && rdy_a && mlst_a && !wh};
      pv_c <= {pv_c[LAT-2:0], mv_c && mlst_c && !wh};
      pd_a[0] <= nacc_a;
      pd_c[0] <= nacc_c;
      for (int i = 1; i < LAT; i++) begin pd_a[i] <= pd_a[i-1]; pd_c[i] <= pd_c[i-1]; end
      if (mv_a && rdy_a) acc_a <= nacc_a;
      if (mv_c) acc_c <= nacc_c;
    end
  end

  int checks = 0, errors = 0;
  int cyc, n_le_a, n_le_b, n_le_c, le_cyc, we_cyc;
  logic [31:0] wseq [$];
  logic [1:0]  beats_a [$];
  logic [1:0]  beats_c [$];
  logic [31:0] oa_a [$];
  logic [31:0] od_a [$];
  logic [31:0] od_b [$];
  logic [31:0] oa_c [$];
  logic [31:0] od_c [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum(input int n, input int ni);
    logic [31:0] s;
    s = b_mem[n];
    for (int k = 0; k < ni; k++) s = s + w_mem[n*ni+k] * x_mem[k];
    return s;
  endfunction

  function automatic logic [31:0] act(input logic [31:0] v, input bit bypass);
    return (!bypass && v[31]) ? 32'h0000_0000 : v;
  endfunction

  // Observe all DUTs at the falling edge, then move to just after the next rising edge.
  task automatic sample();
    @(negedge CLK);
    cyc++;
    if (mv_a && !rdy_a) begin
      chk("stall_mem_rd", {31'd0, mrd_a}, 32'd0);
      chk("stall_w_addr", {29'd0, wa_a}, wseq.size());
      chk("stall_first", {31'd0, mfst_a}, {31'd0, (beats_a.size() % NI) == 0});
    end
    if (mrd_a) wseq.push_back({29'd0, wa_a});
    if (mv_a && rdy_a) beats_a.push_back({mfst_a, mlst_a});
    if (mv_c) beats_c.push_back({mfst_c, mlst_c});
    if (owe_a) begin oa_a.push_back({31'd0, oadr_a}); od_a.push_back(odat_a); we_cyc = cyc; end
    if (owe_b) od_b.push_back(odat_b);
    if (owe_c) begin oa_c.push_back({31'd0, oadr_c}); od_c.push_back(odat_c); end
    if (le_a) begin n_le_a++; le_cyc = cyc; end
    if (le_b) n_le_b++;
    if (le_c) n_le_c++;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    wseq.delete(); beats_a.delete(); beats_c.delete();
    oa_a.delete(); od_a.delete(); od_b.delete(); oa_c.delete(); od_c.delete();
    n_le_a = 0; n_le_b = 0; n_le_c = 0; cyc = 0; le_cyc = -100; we_cyc = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {24'd0, busy_a, le_a, err_a, mrd_a, mv_a, mfst_a, mlst_a, owe_a}, 32'd0);
    chk({tag, "_addr"}, {25'd0, ia_a, wa_a, ba_a, oadr_a}, 32'd0);
    chk({tag, "_data"}, odat_a, 32'd0);
  endtask

  // One layer pass. mode 0: ready high; 1: beat 1 stalled 3 cycles; 2: random ready.
  task automatic run_pass(input int mode, input bit exp_err);
    int stalls, guard;
    clear_obs();
    stalls = 0;
    guard = 0;
    start = 1'b1;
    sample();
    start = 1'b0;
    while (n_le_a == 0 && guard < 600) begin
      if (mode == 1) begin
        if (mv_a && beats_a.size() == 1 && stalls < 3) begin rdy_a = 1'b0; stalls++; end
        else rdy_a = 1'b1;
      end else if (mode == 2) begin
        rdy_a = ($urandom_range(0, 3) != 0);
      end else begin
        rdy_a = 1'b1;
      end
      start = (guard == 2 || guard == 5);
      sample();
      guard++;
    end
    rdy_a = 1'b1;
    start = 1'b0;
    repeat (6) sample();
    chk("layer_end_a", n_le_a, 32'd1);
    chk("layer_end_b", n_le_b, 32'd1);
    chk("layer_end_c", n_le_c, 32'd1);
    chk("le_after_we", le_cyc - we_cyc, 32'd1);
    chk("busy_idle", {31'd0, busy_a}, 32'd0);
    chk("err_a", {31'd0, err_a}, {31'd0, exp_err});
    chk("err_c", {31'd0, err_c}, {31'd0, exp_err});
    chk("rd_count", wseq.size(), NN*NI);
    foreach (wseq[i]) chk($sformatf("w_addr[%0d]", i), wseq[i], i);
    chk("beat_count", beats_a.size(), NN*NI);
    foreach (beats_a[i]) chk($sformatf("frame_a[%0d]", i), {30'd0, beats_a[i]},
                             {30'd0, (i % NI) == 0, (i % NI) == NI-1});
    chk("beat_count_c", beats_c.size(), NN*NIC);
    foreach (beats_c[i]) chk($sformatf("frame_c[%0d]", i), {30'd0, beats_c[i]}, 32'd3);
    chk("writes_a", oa_a.size(), NN);
    chk("writes_b", od_b.size(), NN);
    chk("writes_c", oa_c.size(), NN);
    for (int n = 0; n < NN; n++) begin
      chk($sformatf("out_addr_a[%0d]", n), oa_a[n], n);
      chk($sformatf("out_addr_c[%0d]", n), oa_c[n], n);
      chk($sformatf("out_data_a[%0d]", n), od_a[n], exp_err ? 32'd0 : act(ref_sum(n, NI), 1'b0));
      chk($sformatf("out_data_b[%0d]", n), od_b[n], exp_err ? 32'd0 : act(ref_sum(n, NI), 1'b1));
      chk($sformatf("out_data_c[%0d]", n), od_c[n], exp_err ? 32'd0 : act(ref_sum(n, NIC), 1'b0));
    end
  endtask

  task automatic fill_rand();
    foreach (x_mem[i]) x_mem[i] = $urandom;
    foreach (w_mem[i]) w_mem[i] = $urandom;
    foreach (b_mem[i]) b_mem[i] = $urandom;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rdy_a = 1'b1; wh = 1'b0;
    fill_rand();
    clear_obs();
    repeat (3) sample();
    chk_zero("reset");
    reset = 1'b0;
    sample();

    // Neuron 0 sums to -3.0: clamped in the hidden layer, passed in the final layer.
    b_mem[0] = 32'hC040_0000;
    w_mem[0] = 32'd0; w_mem[1] = 32'd0; w_mem[2] = 32'd0;
    run_pass(0, 1'b0);
    chk("neg3_hidden", od_a[0], 32'h0000_0000);
    chk("neg3_final", od_b[0], 32'hC040_0000);

    fill_rand();
    run_pass(1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      fill_rand();
      run_pass(2, 1'b0);
    end

    // Results withheld: every neuron times out, err sticks, the layer still completes.
    fill_rand();
    wh = 1'b1;
    run_pass(0, 1'b1);
    wh = 1'b0;
    reset = 1'b1;
    sample();
    reset = 1'b0;
    chk("err_cleared", {31'd0, err_a}, 32'd0);

    // Reset while issuing neuron 1 aborts the pass without a layer_end.
    clear_obs();
    start = 1'b1;
    sample();
    start = 1'b0;
    for (int g = 0; g < 200 && !(ba_a == 1'b1 && mrd_a); g++) sample();
    chk("reached_n1_issue", {31'd0, ba_a == 1'b1 && mrd_a}, 32'd1);
    reset = 1'b1;
    sample();
    chk_zero("midreset");
    reset = 1'b0;
    n_le_a = 0;
    repeat (30) sample();
    chk("no_le_after_reset", n_le_a, 32'd0);

    fill_rand();
    run_pass(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
